l2_mshr: RTL
============

L2_MSHR -- requirements
Module: l2_mshr

Interface
REQ-001 SHALL have parameter N_REQS, default 4, number of outstanding-request entries (2..16).
REQ-002 SHALL have parameter WORDS, default 4, words per line; word-mask width.
REQ-003 SHALL have parameter SET_BITS, default 9; parameter TAG_BITS, default 15.
REQ-004 SHALL have parameter INV_BITS, default 4, signed invack-count width.
REQ-005 SHALL have ports with derived widths IDX_W = clog2(N_REQS) and CNT_W = clog2(N_REQS+1).
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  allocation request.
- alloc_tag  in  TAG_BITS  allocation tag.
- alloc_set  in  SET_BITS  allocation set.
- alloc_mask  in  WORDS  words awaited.
- alloc_invack  in  INV_BITS  initial invack count.
- alloc_ready  out  1  a FREE entry exists.
- alloc_idx  out  IDX_W  entry to be allocated.
- upd_valid  in  1  response update.
- upd_idx  in  IDX_W  target entry.
- upd_mask  in  WORDS  words received.
- upd_inv_dec  in  1  decrement invack count by 1.
- lookup_tag  in  TAG_BITS  probe tag.
- lookup_set  in  SET_BITS  probe set.
- lookup_hit  out  1  probe matches tag and set.
- lookup_idx  out  IDX_W  matching entry.
- set_conflict  out  1  probe set matches.
- done_valid  out  1  an entry is COMPLETE.
- done_idx  out  IDX_W  entry offered.
- done_ready  in  1  consumer accepts.
- occupancy  out  CNT_W  non-FREE entries.
- err  out  1  sticky protocol error.

Function
REQ-007 SHALL give each entry a state FREE, PENDING or COMPLETE, plus tag, set, pending mask and signed invack count.
REQ-008 SHALL drive alloc_ready high iff any entry is FREE at cycle start; alloc_idx is the lowest-index FREE entry.
REQ-009 SHALL, on alloc_valid&&alloc_ready, load the entry and move it FREE->PENDING at the next edge.
REQ-010 SHALL, for upd_valid to a PENDING entry, clear pending-mask bits set in upd_mask and subtract 1 from the count when upd_inv_dec is high.
REQ-011 SHALL treat the invack count as two's complement; negative values are legal (invacks before data); no saturation; wrap is a caller error.
REQ-012 SHALL move an entry PENDING->COMPLETE at the edge where its updated mask is zero and updated count is zero, including when both are already zero at allocation.
REQ-013 SHALL set done_valid iff any entry is COMPLETE; done_idx is the lowest-index COMPLETE entry and is held stable until accepted.
REQ-014 SHALL, on done_valid&&done_ready, move the done_idx entry COMPLETE->FREE.
REQ-015 SHALL not offer a freed entry to alloc until the following cycle.
REQ-016 SHALL compute lookup_hit, lookup_idx and set_conflict combinationally over non-FREE entries only.
REQ-017 SHALL give lookup_idx the lowest matching index; it is 0 when there is no hit.
REQ-018 SHALL register occupancy, updated each edge by +alloc -retire; simultaneous alloc and retire leave it unchanged.
REQ-019 SHALL process alloc, update and retire in the same cycle independently; an update to an entry retiring that cycle sets err.
REQ-020 SHALL ignore an update to a FREE or COMPLETE entry, or with upd_idx >= N_REQS, and set err; err clears only on reset.
REQ-021 SHALL drop alloc_valid while alloc_ready is low without state change.

Reset
REQ-022 SHALL on rst low immediately set all entries FREE, clear masks, counts and err, and zero occupancy.
REQ-023 SHALL give these output values during and after reset: alloc_ready=1, alloc_idx=0, done_valid=0, lookup_hit=0, set_conflict=0.
REQ-024 SHALL discard in-flight entries on reset mid-operation; no done is generated for them.

Verification
REQ-025 SHALL pass: alloc tag 0x12, set 5, mask 4'b1111, invack 0 -> idx 0, occupancy 1; upd 4'b0011 then upd 4'b1100 -> done_valid with done_idx 0 one cycle later; done_ready -> occupancy 0.
REQ-026 SHALL pass: invack 2 with mask 0; two upd_inv_dec, then a third -> after the second decrement done_valid; the third sets err.
REQ-027 SHALL pass: upd_inv_dec before data on an entry with invack 0 -> count -1, PENDING; upd mask all plus upd_inv_dec=0, then alloc-style increment is impossible; entry remains PENDING (no completion at -1).
REQ-028 SHALL pass: four allocs fill the entries -> alloc_ready=0, occupancy 4; retire idx 2 and alloc in the same cycle -> alloc rejected that cycle; next cycle alloc_idx=2.
REQ-029 SHALL pass: entries with set 5 (tag A) and set 5 (tag B) -> probe (B,5) gives lookup_hit=1, lookup_idx=1, set_conflict=1; probe (C,5) gives hit 0, conflict 1.
REQ-030 SHALL pass: rst low with 3 PENDING entries -> next cycle occupancy 0, alloc_idx 0, no done.

Source files
------------

// File: rtl/l2_mshr.sv
// L2 miss-status holding registers: tracks outstanding line fills awaiting data words and
// invalidation acks, offers completed entries for retirement, and answers tag/set probes.
module l2_mshr #(
   parameter int unsigned N_REQS   = 4,
   parameter int unsigned WORDS    = 4,
   parameter int unsigned SET_BITS = 9,
   parameter int unsigned TAG_BITS = 15,
   parameter int unsigned INV_BITS = 4,
   localparam int unsigned IDX_W   = $clog2(N_REQS),
   localparam int unsigned CNT_W   = $clog2(N_REQS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   input  logic [TAG_BITS-1:0] alloc_tag,
   input  logic [SET_BITS-1:0] alloc_set,
   input  logic [WORDS-1:0]    alloc_mask,
   input  logic [INV_BITS-1:0] alloc_invack,
   output logic                alloc_ready,
   output logic [IDX_W-1:0]    alloc_idx,
   input  logic                upd_valid,
   input  logic [IDX_W-1:0]    upd_idx,
   input  logic [WORDS-1:0]    upd_mask,
   input  logic                upd_inv_dec,
   input  logic [TAG_BITS-1:0] lookup_tag,
   input  logic [SET_BITS-1:0] lookup_set,
   output logic                lookup_hit,
   output logic [IDX_W-1:0]    lookup_idx,
   output logic                set_conflict,
   output logic                done_valid,
   output logic [IDX_W-1:0]    done_idx,
   input  logic                done_ready,
   output logic [CNT_W-1:0]    occupancy,
   output logic                err
);

   localparam logic [1:0] StFree = 2'd0;
   localparam logic [1:0] StPend = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]          state_q [N_REQS];
   logic [1:0]          state_d [N_REQS];
   logic [TAG_BITS-1:0] tag_q   [N_REQS];
   logic [TAG_BITS-1:0] tag_d   [N_REQS];
   logic [SET_BITS-1:0] set_q   [N_REQS];
   logic [SET_BITS-1:0] set_d   [N_REQS];
   logic [WORDS-1:0]    mask_q  [N_REQS];
   logic [WORDS-1:0]    mask_d  [N_REQS];
   logic [INV_BITS-1:0] cnt_q   [N_REQS];
   logic [INV_BITS-1:0] cnt_d   [N_REQS];

   logic [CNT_W-1:0] occ_q, occ_d;
   logic             err_q, err_d;
   logic             done_hold_q, done_hold_d;
   logic [IDX_W-1:0] done_idx_q, done_idx_d;

   logic [IDX_W-1:0] free_idx, done_low;
   logic             done_any, upd_pend;
   logic             alloc_fire, retire_fire;

   // Priority scans: descending loops leave the lowest matching index in place.
   always_comb begin
      alloc_ready  = 1'b0;
      free_idx     = '0;
      done_any     = 1'b0;
      done_low     = '0;
      lookup_hit   = 1'b0;
      lookup_idx   = '0;
      set_conflict = 1'b0;
      upd_pend     = 1'b0;
      for (int i = N_REQS - 1; i >= 0; i--) begin
         if (state_q[i] == StFree) begin
            alloc_ready = 1'b1;
            free_idx    = IDX_W'(i);
         end
         if (state_q[i] == StDone) begin
            done_any = 1'b1;
            done_low = IDX_W'(i);
         end
         if (state_q[i] != StFree && set_q[i] == lookup_set) begin
            set_conflict = 1'b1;
            if (tag_q[i] == lookup_tag) begin
               lookup_hit = 1'b1;
               lookup_idx = IDX_W'(i);
            end
         end
         if (state_q[i] == StPend && IDX_W'(i) == upd_idx) begin
            upd_pend = 1'b1;
         end
      end
   end

   assign alloc_idx   = free_idx;
   assign done_valid  = done_any;
   // Once offered, the index is frozen so a lower entry completing later cannot steal the slot.
   assign done_idx    = done_hold_q ? done_idx_q : done_low;
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign retire_fire = done_valid & done_ready;
   assign occupancy   = occ_q;
   assign err         = err_q;

   always_comb begin
      for (int i = 0; i < N_REQS; i++) begin
         state_d[i] = state_q[i];
         tag_d[i]   = tag_q[i];
         set_d[i]   = set_q[i];
         mask_d[i]  = mask_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            StFree: begin
               if (alloc_fire && free_idx == IDX_W'(i)) begin
                  state_d[i] = StPend;
                  tag_d[i]   = alloc_tag;
                  set_d[i]   = alloc_set;
                  mask_d[i]  = alloc_mask;
                  cnt_d[i]   = alloc_invack;
               end
            end
            StPend: begin
               if (upd_valid && upd_idx == IDX_W'(i)) begin
                  mask_d[i] = mask_q[i] & ~upd_mask;
                  // Two's-complement wrap is intentional: invacks may arrive before data.
                  cnt_d[i]  = cnt_q[i] - {{(INV_BITS - 1){1'b0}}, upd_inv_dec};
               end
               if (mask_d[i] == '0 && cnt_d[i] == '0) begin
                  state_d[i] = StDone;
               end
            end
            StDone: begin
               if (retire_fire && done_idx == IDX_W'(i)) begin
                  state_d[i] = StFree;
                  mask_d[i]  = '0;
                  cnt_d[i]   = '0;
               end
            end
            default: state_d[i] = StFree;
         endcase
      end
   end

   always_comb begin
      occ_d       = occ_q + CNT_W'(alloc_fire) - CNT_W'(retire_fire);
      err_d       = err_q | (upd_valid & ~upd_pend);
      done_hold_d = done_valid & ~done_ready;
      done_idx_d  = done_idx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQS; i++) begin
            state_q[i] <= StFree;
            tag_q[i]   <= '0;
            set_q[i]   <= '0;
            mask_q[i]  <= '0;
            cnt_q[i]   <= '0;
         end
         occ_q       <= '0;
         err_q       <= 1'b0;
         done_hold_q <= 1'b0;
         done_idx_q  <= '0;
      end else begin
         for (int i = 0; i < N_REQS; i++) begin
            state_q[i] <= state_d[i];
            tag_q[i]   <= tag_d[i];
            set_q[i]   <= set_d[i];
            mask_q[i]  <= mask_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         occ_q       <= occ_d;
         err_q       <= err_d;
         done_hold_q <= done_hold_d;
         done_idx_q  <= done_idx_d;
      end
   end

endmodule
